// File: rtl/up_down_counter.sv
// Up/down modulo counter with run-time limit, synchronous load and wrap/saturate/one-shot terminals.
// Latency 1 cycle for count/ovf/unf; no backpressure, one step is taken on every enabled edge.
module up_down_counter #(
   parameter int WIDTH             = 16,
   parameter bit RESET_LIMIT_CHECK = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] limit,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic             unf,
   output logic             at_limit,
   output logic             at_zero,
   output logic             done
);

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'd0,
      MODE_SAT     = 2'd1,
      MODE_ONESHOT = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_t;

   mode_t            mode_e;
   logic [WIDTH-1:0] load_eff;
   logic [WIDTH-1:0] count_nxt;
   logic             ovf_nxt;
   logic             unf_nxt;
   logic             done_set;
   logic             step_ok;

   assign mode_e   = mode_t'(mode);
   assign at_limit = (count == limit);
   assign at_zero  = (count == '0);

   // An out-of-range load is either clamped here or left for the next step to pull back.
   assign load_eff = (RESET_LIMIT_CHECK && (load_value > limit)) ? limit : load_value;

   // A finished one-shot ignores steps until clr or load re-arms it.
   assign step_ok  = en && !((mode_e == MODE_ONESHOT) && done);

   always_comb begin
      count_nxt = count;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
      done_set  = 1'b0;
      if (load) begin
         count_nxt = load_eff;
      end else if (step_ok) begin
         if (count > limit) begin
            count_nxt = limit;
         end else if (dir) begin
            if (count == limit) begin
               ovf_nxt = 1'b1;
               case (mode_e)
                  MODE_SAT:     count_nxt = count;
                  MODE_ONESHOT: done_set  = 1'b1;
                  default:      count_nxt = '0;
               endcase
            end else begin
               count_nxt = count + WIDTH'(1);
            end
         end else begin
            if (count == '0) begin
               unf_nxt = 1'b1;
               case (mode_e)
                  MODE_SAT:     count_nxt = count;
                  MODE_ONESHOT: done_set  = 1'b1;
                  default:      count_nxt = limit;
               endcase
            end else begin
               count_nxt = count - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         done  <= 1'b0;
      end else begin
         count <= count_nxt;
         ovf   <= ovf_nxt;
         unf   <= unf_nxt;
         // A terminal event in the same cycle as clr leaves done set.
         if (done_set)
            done <= 1'b1;
         else if (load || clr)
            done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_up_down_counter.sv
// Directed-vector bench for up_down_counter (WIDTH=16, no load clamping).
module tb_up_down_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        dir;
   logic        load;
   logic [15:0] load_value;
   logic [15:0] limit;
   logic [1:0]  mode;
   logic        clr;
   logic [15:0] count;
   logic        ovf;
   logic        unf;
   logic        at_limit;
   logic        at_zero;
   logic        done;

   int vectors = 0;
   int errors  = 0;

   up_down_counter #(.WIDTH(16), .RESET_LIMIT_CHECK(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .dir        (dir),
      .load       (load),
      .load_value (load_value),
      .limit      (limit),
      .mode       (mode),
      .clr        (clr),
      .count      (count),
      .ovf        (ovf),
      .unf        (unf),
      .at_limit   (at_limit),
      .at_zero    (at_zero),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_value = 16'd0;
      limit = 16'd25; mode = 2'd0; clr = 1'b0;
      #3;
      chk("rst_count", count, 16'd0);
      chk("rst_ovf", 16'(ovf), 16'd0);
      chk("rst_unf", 16'(unf), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_at_zero", 16'(at_zero), 16'd1);
      step();

      // Wrap up-count to 25 then roll over with a single ovf pulse.
      rst = 1'b0; en = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         step();
         chk("wrap_up_count", count, 16'(i));
         chk("wrap_up_ovf", 16'(ovf), 16'd0);
      end
      chk("wrap_at_limit", 16'(at_limit), 16'd1);
      step();
      chk("wrap_roll_count", count, 16'd0);
      chk("wrap_roll_ovf", 16'(ovf), 16'd1);
      chk("wrap_roll_at_limit", 16'(at_limit), 16'd0);
      step();
      chk("wrap_after_count", count, 16'd1);
      chk("wrap_after_ovf", 16'(ovf), 16'd0);
      en = 1'b0;
      step();
      chk("hold_count", count, 16'd1);

      // Saturate at limit, ovf repeats each enabled cycle.
      mode = 2'd1; load = 1'b1; load_value = 16'd24;
      step();
      chk("sat_load", count, 16'd24);
      load = 1'b0; en = 1'b1;
      step();
      chk("sat_s1_count", count, 16'd25);
      chk("sat_s1_ovf", 16'(ovf), 16'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sat_count", count, 16'd25);
         chk("sat_ovf", 16'(ovf), 16'd1);
      end
      en = 1'b0;
      step();
      chk("sat_idle_ovf", 16'(ovf), 16'd0);

      // One-shot down from 3.
      mode = 2'd2; dir = 1'b0; load = 1'b1; load_value = 16'd3;
      step();
      chk("os_load", count, 16'd3);
      load = 1'b0; en = 1'b1;
      step(); chk("os_c2", count, 16'd2);
      step(); chk("os_c1", count, 16'd1);
      step(); chk("os_c0", count, 16'd0); chk("os_c0_unf", 16'(unf), 16'd0);
      step();
      chk("os_term_count", count, 16'd0);
      chk("os_term_unf", 16'(unf), 16'd1);
      chk("os_term_done", 16'(done), 16'd1);
      step();
      chk("os_idle_unf", 16'(unf), 16'd0);
      chk("os_idle_done", 16'(done), 16'd1);
      step();
      chk("os_idle2_unf", 16'(unf), 16'd0);
      en = 1'b0; clr = 1'b1;
      step();
      chk("os_clr_done", 16'(done), 16'd0);
      clr = 1'b0; en = 1'b1;
      step();
      chk("os_rearm_unf", 16'(unf), 16'd1);
      chk("os_rearm_done", 16'(done), 16'd1);
      en = 1'b0; load = 1'b1; load_value = 16'd0;
      step();
      chk("os_load_clears_done", 16'(done), 16'd0);
      chk("os_load_no_unf", 16'(unf), 16'd0);
      load = 1'b0; en = 1'b1; clr = 1'b1;
      step();
      chk("os_clr_vs_set_done", 16'(done), 16'd1);
      chk("os_clr_vs_set_unf", 16'(unf), 16'd1);
      clr = 1'b0; en = 1'b0;

      // Load overrides en; then a down-step.
      mode = 2'd0; limit = 16'hFFFF; dir = 1'b1; load = 1'b1; en = 1'b1; load_value = 16'h0100;
      step();
      chk("load_over_en", count, 16'h0100);
      load = 1'b0; dir = 1'b0;
      step();
      chk("load_then_down", count, 16'h00FF);
      en = 1'b0;

      // Lowering limit below count.
      limit = 16'd25; load = 1'b1; load_value = 16'd20;
      step();
      chk("lim_load", count, 16'd20);
      load = 1'b0; limit = 16'd10; dir = 1'b1; en = 1'b1;
      step();
      chk("lim_clamp_count", count, 16'd10);
      chk("lim_clamp_ovf", 16'(ovf), 16'd0);
      chk("lim_at_limit", 16'(at_limit), 16'd1);
      step();
      chk("lim_wrap_count", count, 16'd0);
      chk("lim_wrap_ovf", 16'(ovf), 16'd1);
      en = 1'b0; load = 1'b1; load_value = 16'd20;
      step();
      chk("lim_verbatim_load", count, 16'd20);
      load = 1'b0; dir = 1'b0; en = 1'b1;
      step();
      chk("lim_down_clamp", count, 16'd10);
      chk("lim_down_unf", 16'(unf), 16'd0);
      step();
      chk("lim_down_dec", count, 16'd9);

      // Down wrap from zero reloads limit.
      en = 1'b0; load = 1'b1; load_value = 16'd0;
      step();
      load = 1'b0; en = 1'b1;
      step();
      chk("down_wrap_count", count, 16'd10);
      chk("down_wrap_unf", 16'(unf), 16'd1);

      // limit=0 in wrap mode.
      en = 1'b0; limit = 16'd0; load = 1'b1; load_value = 16'd0;
      step();
      load = 1'b0; en = 1'b1; dir = 1'b1;
      step();
      chk("lim0_up_count", count, 16'd0);
      chk("lim0_up_ovf", 16'(ovf), 16'd1);
      dir = 1'b0;
      step();
      chk("lim0_dn_count", count, 16'd0);
      chk("lim0_dn_unf", 16'(unf), 16'd1);
      chk("lim0_dn_ovf", 16'(ovf), 16'd0);

      // Reserved mode acts as wrap.
      en = 1'b0; mode = 2'd3; limit = 16'd5; load = 1'b1; load_value = 16'd5;
      step();
      load = 1'b0; en = 1'b1; dir = 1'b1;
      step();
      chk("rsvd_wrap_count", count, 16'd0);
      chk("rsvd_wrap_ovf", 16'(ovf), 16'd1);
      chk("rsvd_wrap_done", 16'(done), 16'd0);

      // Asynchronous reset mid-count.
      mode = 2'd0; limit = 16'd25; en = 1'b0; load = 1'b1; load_value = 16'd16;
      step();
      load = 1'b0; en = 1'b1;
      step();
      chk("pre_rst_count", count, 16'd17);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", count, 16'd0);
      chk("async_rst_ovf", 16'(ovf), 16'd0);
      step();
      chk("rst_held_count", count, 16'd0);
      rst = 1'b0;
      step();
      chk("post_rst_first", count, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
